// File: rtl/fpu_cmd_queue_if.sv
// Handshake bundle between the FPU register block (command/result side) and the
// FPU core (issue/done side), as seen by fpu_cmd_queue.
interface fpu_cmd_queue_if;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_din1;
    logic [31:0] cmd_din2;
    logic        res_val;
    logic        res_rdy;
    logic [31:0] res_data;
    logic        core_val;
    logic [3:0]  core_cmd;
    logic [31:0] core_din1;
    logic [31:0] core_din2;
    logic [31:0] core_result;
    logic        core_rdy;

    modport master (
        output cmd_val, cmd_op, cmd_din1, cmd_din2, res_rdy, core_result, core_rdy,
        input  cmd_rdy, res_val, res_data, core_val, core_cmd, core_din1, core_din2
    );

    modport slave (
        input  cmd_val, cmd_op, cmd_din1, cmd_din2, res_rdy, core_result, core_rdy,
        output cmd_rdy, res_val, res_data, core_val, core_cmd, core_din1, core_din2
    );
endinterface

// File: rtl/fpu_cmd_queue.sv
// Command/result buffering stage between the FPU register block and the FPU core.
// Optional core watchdog is enabled by defining FPU_QUEUE_TIMEOUT_EN.
module fpu_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic           mclk,
    input  logic           rst_n,
    input  logic           flush,
    fpu_cmd_queue_if.slave bus,
    output logic [PTR_W:0] cmd_cnt,
    output logic           err,
    output logic           idle
);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [67:0]       cmd_mem_r [DEPTH];
    logic [31:0]       res_mem_r [DEPTH];
    logic [PTR_W-1:0]  cmd_wp_r, cmd_rp_r, res_wp_r, res_rp_r;
    logic [PTR_W:0]    cmd_cnt_r, res_cnt_r, issued_s;
    logic [3:0]        core_cmd_r;
    logic [31:0]       core_din1_r, core_din2_r, res_in_s;
    logic              clr_s, cmd_push_s, issue_s, res_push_s, res_pop_s, timeout_s;

    assign clr_s      = !rst_n || flush;
    assign cmd_push_s = bus.cmd_val && (cmd_cnt_r != CNT_FULL);
    assign res_pop_s  = bus.res_rdy && (res_cnt_r != CNT_ZERO);
    // A command in ISSUE/WAIT already owns a result slot, so a result push never overflows
    assign issued_s   = res_cnt_r + ((state_r != ST_IDLE) ? CNT_ONE : CNT_ZERO);
    assign issue_s    = (state_r == ST_IDLE) && (cmd_cnt_r != CNT_ZERO) && (issued_s < CNT_FULL);
    assign res_in_s   = timeout_s ? QNAN : bus.core_result;

    // FSM state register
    always_ff @(posedge mclk) begin
        if (clr_s) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next state and result push strobe
    always_comb begin
        state_nxt_s = state_r;
        res_push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) state_nxt_s = ST_ISSUE;
                else         state_nxt_s = ST_IDLE;
            end
            ST_ISSUE, ST_WAIT: begin
                if (bus.core_rdy || timeout_s) begin
                    res_push_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge mclk) begin
        if (clr_s) begin
            cmd_wp_r  <= PTR_ZERO;
            cmd_rp_r  <= PTR_ZERO;
            cmd_cnt_r <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) cmd_mem_r[i] <= 68'd0;
        end else begin
            if (cmd_push_s) begin
                cmd_mem_r[cmd_wp_r] <= {bus.cmd_op, bus.cmd_din1, bus.cmd_din2};
                cmd_wp_r            <= cmd_wp_r + PTR_ONE;
            end
            if (issue_s) cmd_rp_r <= cmd_rp_r + PTR_ONE;
            case ({cmd_push_s, issue_s})
                2'b10:   cmd_cnt_r <= cmd_cnt_r + CNT_ONE;
                2'b01:   cmd_cnt_r <= cmd_cnt_r - CNT_ONE;
                default: cmd_cnt_r <= cmd_cnt_r;
            endcase
        end
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge mclk) begin
        if (clr_s) begin
            res_wp_r  <= PTR_ZERO;
            res_rp_r  <= PTR_ZERO;
            res_cnt_r <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) res_mem_r[i] <= 32'd0;
        end else begin
            if (res_push_s) begin
                res_mem_r[res_wp_r] <= res_in_s;
                res_wp_r            <= res_wp_r + PTR_ONE;
            end
            if (res_pop_s) res_rp_r <= res_rp_r + PTR_ONE;
            case ({res_push_s, res_pop_s})
                2'b10:   res_cnt_r <= res_cnt_r + CNT_ONE;
                2'b01:   res_cnt_r <= res_cnt_r - CNT_ONE;
                default: res_cnt_r <= res_cnt_r;
            endcase
        end
    end

    // Issue registers hold the last issued operation until the next issue
    always_ff @(posedge mclk) begin
        if (clr_s) begin
            core_cmd_r  <= 4'd0;
            core_din1_r <= 32'd0;
            core_din2_r <= 32'd0;
        end else if (issue_s) begin
            {core_cmd_r, core_din1_r, core_din2_r} <= cmd_mem_r[cmd_rp_r];
        end
    end

`ifdef FPU_QUEUE_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_r;
    logic            err_r;

    assign timeout_s = (state_r == ST_WAIT) && !bus.core_rdy && (to_cnt_r == TO_LAST);

    // Watchdog counts WAIT cycles of the current issue
    always_ff @(posedge mclk) begin
        if (clr_s || issue_s)          to_cnt_r <= TO_W'(1'b0);
        else if (state_r == ST_WAIT)   to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end

    // Sticky error survives flush; only reset clears it
    always_ff @(posedge mclk) begin
        if (!rst_n)                   err_r <= 1'b0;
        else if (timeout_s && !flush) err_r <= 1'b1;
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    assign bus.cmd_rdy   = (cmd_cnt_r != CNT_FULL);
    assign bus.res_val   = (res_cnt_r != CNT_ZERO);
    assign bus.res_data  = res_mem_r[res_rp_r];
    assign bus.core_val  = (state_r == ST_ISSUE);
    assign bus.core_cmd  = core_cmd_r;
    assign bus.core_din1 = core_din1_r;
    assign bus.core_din2 = core_din2_r;
    assign cmd_cnt       = cmd_cnt_r;
    assign idle          = (state_r == ST_IDLE) && (cmd_cnt_r == CNT_ZERO) && (res_cnt_r == CNT_ZERO);
endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Self-checking bench for fpu_cmd_queue: XOR core model with 3-cycle latency and
// a result scoreboard filled on every accepted command.
module tb_fpu_cmd_queue;
    logic        mclk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  cmd_cnt;
    logic        err;
    logic        idle;

    fpu_cmd_queue_if bus ();

    fpu_cmd_queue #(.DEPTH(4), .PTR_W(2), .TIMEOUT_CYC(255)) dut (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .cmd_cnt (cmd_cnt),
        .err     (err),
        .idle    (idle)
    );

    always #5 mclk = ~mclk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_issue = 0;
    logic [31:0] sb_q[$];
    logic        core_en = 1'b1;
    logic        exp_nan = 1'b0;
    logic [2:0]  core_sh = 3'd0;
    logic        core_rdy_r = 1'b0;
    logic [31:0] core_x = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Core model: result = din1 ^ din2, core_rdy three cycles after core_val
    always @(posedge mclk) begin
        core_sh    <= {core_sh[1:0], bus.core_val & core_en};
        core_rdy_r <= core_sh[1];
        if (bus.core_val) core_x <= bus.core_din1 ^ bus.core_din2;
    end
    assign bus.core_rdy    = core_rdy_r;
    assign bus.core_result = core_x;

    // Scoreboard monitor sampled mid-cycle
    always @(negedge mclk) begin
        if (bus.core_val) n_issue++;
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (bus.res_val && bus.res_rdy) begin
                chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) chk("res_data_order", bus.res_data, sb_q.pop_front());
            end
            if (bus.cmd_val && bus.cmd_rdy)
                sb_q.push_back(exp_nan ? 32'h7FC0_0000 : (bus.cmd_din1 ^ bus.cmd_din2));
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int i;
        bus.cmd_val  = 1'b1;
        bus.cmd_op   = op;
        bus.cmd_din1 = a;
        bus.cmd_din2 = b;
        i = 0;
        while (!bus.cmd_rdy && i < 300) begin
            tick();
            i++;
        end
        if (!bus.cmd_rdy) chk("push_wait", 32'(bus.cmd_rdy), 32'd1);
        tick();
        bus.cmd_val = 1'b0;
    endtask

    task automatic wait_core_val();
        int i;
        i = 0;
        while (!bus.core_val && i < 100) begin
            tick();
            i++;
        end
        if (!bus.core_val) chk("core_val_wait", 32'(bus.core_val), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.cmd_val  = 1'b0;
        bus.cmd_op   = 4'd0;
        bus.cmd_din1 = 32'd0;
        bus.cmd_din2 = 32'd0;
        bus.res_rdy  = 1'b0;
        tick();
        tick();

        chk("rst_cmd_rdy",   32'(bus.cmd_rdy),  32'd1);
        chk("rst_res_val",   32'(bus.res_val),  32'd0);
        chk("rst_core_val",  32'(bus.core_val), 32'd0);
        chk("rst_core_cmd",  32'(bus.core_cmd), 32'd0);
        chk("rst_core_din1", bus.core_din1,     32'd0);
        chk("rst_core_din2", bus.core_din2,     32'd0);
        chk("rst_res_data",  bus.res_data,      32'd0);
        chk("rst_cmd_cnt",   32'(cmd_cnt),      32'd0);
        chk("rst_err",       32'(err),          32'd0);
        chk("rst_idle",      32'(idle),         32'd1);
        rst_n = 1'b1;
        tick();

        // Single op: issue two cycles after push, result four cycles after issue
        push(4'd0, 32'h3F80_0000, 32'h4000_0000);
        chk("single_no_early_issue", 32'(bus.core_val), 32'd0);
        tick();
        chk("single_core_val",  32'(bus.core_val), 32'd1);
        chk("single_core_cmd",  32'(bus.core_cmd), 32'd0);
        chk("single_core_din1", bus.core_din1,     32'h3F80_0000);
        chk("single_core_din2", bus.core_din2,     32'h4000_0000);
        tick();
        chk("single_core_val_pulse", 32'(bus.core_val), 32'd0);
        chk("single_din1_hold",      bus.core_din1,     32'h3F80_0000);
        tick();
        tick();
        chk("single_res_val_early", 32'(bus.res_val), 32'd0);
        tick();
        chk("single_res_val",  32'(bus.res_val), 32'd1);
        chk("single_res_data", bus.res_data,     32'h7F80_0000);
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        chk("single_res_val_after_pop", 32'(bus.res_val), 32'd0);
        chk("single_idle", 32'(idle), 32'd1);

        // Fill and back-pressure: five commands while the result side stalls
        n0 = n_issue;
        for (int k = 0; k < 5; k++) push(4'(k + 1), $urandom, $urandom);
        chk("fill_cmd_cnt", 32'(cmd_cnt),     32'd4);
        chk("fill_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        repeat (60) tick();
        chk("bp_issues",  32'(n_issue - n0), 32'd4);
        chk("bp_cmd_cnt", 32'(cmd_cnt),      32'd1);
        chk("bp_cmd_rdy", 32'(bus.cmd_rdy),  32'd1);
        chk("bp_res_val", 32'(bus.res_val),  32'd1);
        chk("bp_idle",    32'(idle),         32'd0);
        bus.res_rdy = 1'b1;
        repeat (40) tick();
        bus.res_rdy = 1'b0;
        chk("drain_issues", 32'(n_issue - n0), 32'd5);
        chk("drain_sb",     32'(sb_q.size()),  32'd0);
        chk("drain_idle",   32'(idle),         32'd1);

        // Random stream with a toggling consumer
        fork
            begin
                for (int k = 0; k < 10; k++) push(4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            begin
                for (int j = 0; j < 150; j++) begin
                    bus.res_rdy = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.res_rdy = 1'b1;
            end
        join
        repeat (30) tick();
        bus.res_rdy = 1'b0;
        chk("rand_sb",      32'(sb_q.size()),  32'd0);
        chk("rand_res_val", 32'(bus.res_val),  32'd0);
        chk("rand_idle",    32'(idle),         32'd1);

        // Reset while waiting on the core; the late core_rdy must be dropped
        push(4'd7, $urandom, $urandom);
        wait_core_val();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rstmid_cmd_cnt", 32'(cmd_cnt),     32'd0);
        chk("rstmid_res_val", 32'(bus.res_val), 32'd0);
        chk("rstmid_idle",    32'(idle),        32'd1);

        // Flush with two queued commands and one in flight
        push(4'd1, $urandom, $urandom);
        push(4'd2, $urandom, $urandom);
        push(4'd3, $urandom, $urandom);
        chk("flush_pre_cnt", 32'(cmd_cnt), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_cmd_cnt", 32'(cmd_cnt),     32'd0);
        chk("flush_res_val", 32'(bus.res_val), 32'd0);
        chk("flush_idle",    32'(idle),        32'd1);
        chk("flush_err",     32'(err),         32'd0);
        repeat (6) tick();
        chk("flush_no_late_res", 32'(bus.res_val),  32'd0);
        chk("flush_res_data",    bus.res_data,      32'd0);
        chk("flush_no_reissue",  32'(bus.core_val), 32'd0);

`ifdef FPU_QUEUE_TIMEOUT_EN
        // Silent core: watchdog substitutes a quiet NaN and raises err
        core_en = 1'b0;
        exp_nan = 1'b1;
        push(4'd9, $urandom, $urandom);
        wait_core_val();
        repeat (255) tick();
        chk("to_res_val_early", 32'(bus.res_val), 32'd0);
        tick();
        chk("to_res_val",  32'(bus.res_val), 32'd1);
        chk("to_res_data", bus.res_data,     32'h7FC0_0000);
        chk("to_err",      32'(err),         32'd1);
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        chk("to_err_sticky", 32'(err), 32'd1);
        exp_nan = 1'b0;
        core_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_cmd_queue.md
Name: fpu_cmd_queue

Overview:
- Command/result buffering stage between the FPU register block's core-side interface and the single-precision FPU core.
- Queues up to DEPTH operation descriptors (cmd, din1, din2) and issues them one at a time to the core using the core's dval/rdy protocol.
- Collects core results in order into a result FIFO, which the register side drains with a valid/ready handshake.
- Lets software post back-to-back FPU operations without polling the core after each one.

Parameters:
- DEPTH, 4, entries in each of the command FIFO and the result FIFO; must be a power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- TIMEOUT_CYC, 255, watchdog limit in mclk cycles; used only when FPU_QUEUE_TIMEOUT_EN is defined.

Ports:
- mclk  in  1  single clock for the whole block
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of both FIFOs and the FSM
- cmd_val  in  1  upstream command valid
- cmd_rdy  out  1  command FIFO not full
- cmd_op  in  4  FPU command code; opaque to this block
- cmd_din1  in  32  operand 1
- cmd_din2  in  32  operand 2
- res_val  out  1  result FIFO not empty
- res_rdy  in  1  upstream consumes the head result
- res_data  out  32  head result
- core_val  out  1  one-cycle issue strobe to the FPU core (dval)
- core_cmd  out  4  issued command
- core_din1  out  32  issued operand 1
- core_din2  out  32  issued operand 2
- core_result  in  32  FPU core result
- core_rdy  in  1  FPU core done pulse
- cmd_cnt  out  PTR_W+1  command FIFO occupancy
- err  out  1  sticky timeout flag
- idle  out  1  block is quiescent

Behaviour:
- Reset (rst_n=0 sampled on a mclk edge):
  - FIFOs emptied, FSM to IDLE.
  - cmd_rdy=1, res_val=0, core_val=0, core_cmd/din1/din2=0, res_data=0, cmd_cnt=0, err=0, idle=1.
  - Reset asserted mid-operation abandons any in-flight command; a later core_rdy is ignored because the FSM is in IDLE.
- Command push:
  - Occurs when cmd_val & cmd_rdy.
  - cmd_rdy = (cmd_cnt != DEPTH).
  - cmd_val while full is held off and not lost; upstream must keep cmd_val asserted.
- Result pop:
  - Occurs when res_val & res_rdy; res_data is the FIFO head (first-word fall-through).
  - res_rdy while empty has no effect.
- Space reservation:
  - issued = (result FIFO count) + (1 if FSM is in ISSUE or WAIT).
  - Issue is permitted only when issued < DEPTH, so a result push can never overflow.
- FSM:
  - IDLE: when the command FIFO is non-empty and the reservation check passes:
    - Register the head entry into core_cmd/din1/din2.
    - Pop the command FIFO.
    - Go to ISSUE.
  - ISSUE: core_val=1 for exactly this cycle, then go to WAIT.
  - WAIT: on core_rdy=1, push core_result into the result FIFO and go to IDLE.
  - core_rdy seen in ISSUE is treated as in WAIT (push result, go to IDLE).
  - core_rdy seen in IDLE is ignored.
- Latency:
  - Command pushed at edge N: core_val is high in cycle N+2.
  - core_rdy at edge M: res_val=1 from cycle M+1.
  - Minimum issue-to-issue spacing is core latency + 2 cycles.
- Simultaneous events:
  - Command push and IDLE pop in the same cycle: cmd_cnt is unchanged.
  - Result push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by the count.
- flush:
  - Same effect as reset except err is held.
  - Any in-flight result is discarded.
  - flush has priority over a push or pop in the same cycle.
- Outputs:
  - idle = FSM in IDLE & command FIFO empty & result FIFO empty.
  - core_* data holds its value after ISSUE until the next issue.

Optional Feature:
- FPU_QUEUE_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYC with no core_rdy, push 32'h7FC0_0000 (quiet NaN), set err=1 (sticky; cleared only by reset), and go to IDLE.
  - The counter clears on every issue.
- FPU_QUEUE_TIMEOUT_EN undefined:
  - WAIT lasts indefinitely; err is tied to 0 and no counter is present.

Test Plan:
- Core model (bench-defined) returns din1^din2 three cycles after core_val.
- Single op: push op=0, din1=32'h3F80_0000, din2=32'h4000_0000.
  - core_val is high exactly 1 cycle, 2 cycles after the push.
  - res_data=32'h7F80_0000, res_val rises 4 cycles after core_val; idle=1 after the pop.
- Fill: res_rdy=0, push 5 commands with DEPTH=4.
  - cmd_rdy drops after the 4th push, and after one issue reopens for the 5th.
  - The 5th command is not issued until a result is popped.
  - Results emerge in push order.
- Back-pressure: hold res_rdy=0 until the result FIFO holds 4 entries.
  - No further core_val pulses.
  - Setting res_rdy=1 drains 4 results and issue resumes.
- Reset mid-op: rst_n=0 during WAIT with a pending core_rdy.
  - After release, cmd_cnt=0, res_val=0, idle=1.
  - The stale core_rdy produces no result.
- Flush with 2 queued commands and 1 in flight: all FIFOs empty next cycle, no result is produced, err is unchanged.
- With FPU_QUEUE_TIMEOUT_EN and the core model never asserting core_rdy: after 255 WAIT cycles, res_data=32'h7FC0_0000 and err=1, still 1 after the pop.
